// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-access stage of the 8-bit pipeline:
//   DMEM_DATA_W / DMEM_ADDR_W : default data-memory word and address widths
//   wb_sel_e                  : write-back source encoding
//   wb_select()               : priority encoder for the write-back source
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam int DMEM_DATA_W = 8;
   localparam int DMEM_ADDR_W = 8;

   typedef enum logic [1:0] {
      WB_SEL_ALU    = 2'd0,
      WB_SEL_INPORT = 2'd1,
      WB_SEL_MEM    = 2'd2
   } wb_sel_e;

   // Memory read data wins over the input port, which wins over the ALU.
   function automatic wb_sel_e wb_select(input logic rdata_sel, input logic out_sel);
      if (rdata_sel)
         return WB_SEL_MEM;
      else if (out_sel)
         return WB_SEL_INPORT;
      return WB_SEL_ALU;
   endfunction

endpackage

// File: rtl/dmem_sync.sv
// -----------------------------------------------------------------------------
// dmem_sync
// Single-port synchronous RAM, read-first, depth 2^ADDR_W, no reset.
//   clk  : clock
//   we   : write enable
//   addr : read/write address
//   wd   : write data
//   rd   : registered read data (old contents when written the same cycle)
// -----------------------------------------------------------------------------
module dmem_sync
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array has no reset so it maps onto block RAM; resetting it
   // would force a flop-based implementation.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wd;
      // NOTE: non-blocking assignments make this read see the pre-write
      // contents, which is what gives read-first behaviour.
      rd <= mem[addr];
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage: data memory, output port, RET return-address pop and
// the MEM/WB pipeline register. All outputs have one cycle of latency from
// the *_M inputs.
//   clk, reset          : clock, asynchronous active-low reset
//   wr_en_regf_M        : instruction writes the register file
//   wr_en_dmem_M        : store
//   rd_en_M             : load
//   out_port_sel_M      : OUT instruction
//   is_ret_M            : RET, pop return address
//   mux_out_sel_M       : write back IN_PORT_M
//   mux_rdata_sel_M     : write back memory read data (highest priority)
//   alu_out_M, rd_M, IN_PORT_M, mem_addr_M, mem_wd_M : datapath inputs
//   wr_en_regf_W, rd_W, wb_data_W : write-back bundle
//   out_port            : output port register
//   ret_pc_valid/ret_pc : popped return address, one-cycle valid pulse
//   addr_err            : sticky out-of-range access flag
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_regf_M,
   input  logic              wr_en_dmem_M,
   input  logic              rd_en_M,
   input  logic              out_port_sel_M,
   input  logic              is_ret_M,
   input  logic              mux_out_sel_M,
   input  logic              mux_rdata_sel_M,
   input  logic [15:0]       alu_out_M,
   input  logic [1:0]        rd_M,
   input  logic [7:0]        IN_PORT_M,
   input  logic [15:0]       mem_addr_M,
   input  logic [15:0]       mem_wd_M,
   output logic              wr_en_regf_W,
   output logic [1:0]        rd_W,
   output logic [DATA_W-1:0] wb_data_W,
   output logic [7:0]        out_port,
   output logic              ret_pc_valid,
   output logic [DATA_W-1:0] ret_pc,
   output logic              addr_err
);

   logic              in_range;
   logic              oor_access;
   wb_sel_e           wb_sel;
   wb_sel_e           wb_sel_q;
   logic [DATA_W-1:0] pre_data;
   logic [DATA_W-1:0] pre_q;
   logic              oor_q;
   logic [DATA_W-1:0] ram_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] ret_hold_q;

   // Only the low bits of the 16-bit datapath buses are consumed here.
   logic unused_hi;
   assign unused_hi = ^{alu_out_M[15:DATA_W], mem_wd_M[15:DATA_W]};

   assign in_range   = (mem_addr_M[15:ADDR_W] == '0);
   assign oor_access = ~in_range & (wr_en_dmem_M | rd_en_M | is_ret_M);
   assign wb_sel     = wb_select(mux_rdata_sel_M, mux_out_sel_M);

   // Non-memory write-back data is resolved now; memory data only exists
   // after the RAM's own register, so the final mux sits behind it.
   always_comb begin
      // NOTE: default first so every path assigns pre_data and no latch forms.
      pre_data = alu_out_M[DATA_W-1:0];
      if (wb_sel == WB_SEL_INPORT)
         pre_data = DATA_W'(IN_PORT_M);
   end

   dmem_sync #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk  (clk),
      .we   (wr_en_dmem_M & in_range),
      .addr (mem_addr_M[ADDR_W-1:0]),
      .wd   (mem_wd_M[DATA_W-1:0]),
      .rd   (ram_rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en_regf_W <= 1'b0;
         rd_W         <= '0;
         wb_sel_q     <= WB_SEL_ALU;
         pre_q        <= '0;
         oor_q        <= 1'b0;
         out_port     <= '0;
         ret_pc_valid <= 1'b0;
         ret_hold_q   <= '0;
         addr_err     <= 1'b0;
      end else begin
         wr_en_regf_W <= wr_en_regf_M;
         rd_W         <= rd_M;
         wb_sel_q     <= wb_sel;
         pre_q        <= pre_data;
         oor_q        <= ~in_range;
         if (out_port_sel_M)
            out_port <= alu_out_M[7:0];
         ret_pc_valid <= is_ret_M;
         // Freeze the popped address at the end of the pulse so it holds.
         if (ret_pc_valid)
            ret_hold_q <= mem_rdata;
         addr_err <= addr_err | oor_access;
      end
   end

   // Out-of-range loads and RETs read as zero. After reset wb_sel_q selects
   // pre_q and ret_pc_valid is low, so the un-reset RAM never reaches a port.
   assign mem_rdata = oor_q ? '0 : ram_rd;
   assign wb_data_W = (wb_sel_q == WB_SEL_MEM) ? mem_rdata : pre_q;
   assign ret_pc    = ret_pc_valid ? mem_rdata : ret_hold_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed testbench for mem_stage. Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        wr_en_regf_M;
   logic        wr_en_dmem_M;
   logic        rd_en_M;
   logic        out_port_sel_M;
   logic        is_ret_M;
   logic        mux_out_sel_M;
   logic        mux_rdata_sel_M;
   logic [15:0] alu_out_M;
   logic [1:0]  rd_M;
   logic [7:0]  IN_PORT_M;
   logic [15:0] mem_addr_M;
   logic [15:0] mem_wd_M;
   logic        wr_en_regf_W;
   logic [1:0]  rd_W;
   logic [7:0]  wb_data_W;
   logic [7:0]  out_port;
   logic        ret_pc_valid;
   logic [7:0]  ret_pc;
   logic        addr_err;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en_regf_M    (wr_en_regf_M),
      .wr_en_dmem_M    (wr_en_dmem_M),
      .rd_en_M         (rd_en_M),
      .out_port_sel_M  (out_port_sel_M),
      .is_ret_M        (is_ret_M),
      .mux_out_sel_M   (mux_out_sel_M),
      .mux_rdata_sel_M (mux_rdata_sel_M),
      .alu_out_M       (alu_out_M),
      .rd_M            (rd_M),
      .IN_PORT_M       (IN_PORT_M),
      .mem_addr_M      (mem_addr_M),
      .mem_wd_M        (mem_wd_M),
      .wr_en_regf_W    (wr_en_regf_W),
      .rd_W            (rd_W),
      .wb_data_W       (wb_data_W),
      .out_port        (out_port),
      .ret_pc_valid    (ret_pc_valid),
      .ret_pc          (ret_pc),
      .addr_err        (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en_regf_M    = 1'b0;
      wr_en_dmem_M    = 1'b0;
      rd_en_M         = 1'b0;
      out_port_sel_M  = 1'b0;
      is_ret_M        = 1'b0;
      mux_out_sel_M   = 1'b0;
      mux_rdata_sel_M = 1'b0;
      alu_out_M       = 16'h0000;
      rd_M            = 2'd0;
      IN_PORT_M       = 8'h00;
      mem_addr_M      = 16'h0000;
      mem_wd_M        = 16'h0000;
   endtask

   task automatic randomize_inputs();
      wr_en_regf_M    = 1'($urandom);
      wr_en_dmem_M    = 1'($urandom);
      rd_en_M         = 1'($urandom);
      out_port_sel_M  = 1'b1;
      is_ret_M        = 1'b1;
      mux_out_sel_M   = 1'($urandom);
      mux_rdata_sel_M = 1'($urandom);
      alu_out_M       = 16'($urandom) | 16'h0001;
      rd_M            = 2'($urandom) | 2'd1;
      IN_PORT_M       = 8'($urandom);
      mem_addr_M      = 16'h0100 | 16'($urandom_range(0, 255));
      mem_wd_M        = 16'($urandom);
   endtask

   task automatic store(input logic [15:0] addr, input logic [15:0] data);
      idle();
      wr_en_dmem_M = 1'b1;
      mem_addr_M   = addr;
      mem_wd_M     = data;
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " wr_en_regf_W"}, 16'(wr_en_regf_W), 16'h0);
      check({tag, " rd_W"},         16'(rd_W),         16'h0);
      check({tag, " wb_data_W"},    16'(wb_data_W),    16'h0);
      check({tag, " out_port"},     16'(out_port),     16'h0);
      check({tag, " ret_pc_valid"}, 16'(ret_pc_valid), 16'h0);
      check({tag, " ret_pc"},       16'(ret_pc),       16'h0);
      check({tag, " addr_err"},     16'(addr_err),     16'h0);
   endtask

   initial begin
      // Power-up reset, then a few random cycles to load non-zero state
      // (every random access is out of range, so memory is untouched).
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         randomize_inputs();
         tick();
      end
      check("pre_reset addr_err", 16'(addr_err), 16'h1);
      check("pre_reset ret_pc_valid", 16'(ret_pc_valid), 16'h1);

      // Asynchronous reset mid-cycle with a RET pending.
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("reset_async");
      tick();
      randomize_inputs();
      tick();
      check_all_zero("reset_held");
      reset = 1'b1;
      idle();

      // Store then load the same address in consecutive cycles.
      store(16'h0010, 16'h00A5);
      check("store addr_err", 16'(addr_err), 16'h0);
      idle();
      rd_en_M         = 1'b1;
      mux_rdata_sel_M = 1'b1;
      wr_en_regf_M    = 1'b1;
      rd_M            = 2'd2;
      mem_addr_M      = 16'h0010;
      tick();
      check("load wb_data_W", 16'(wb_data_W), 16'h00A5);
      check("load rd_W", 16'(rd_W), 16'h0002);
      check("load wr_en_regf_W", 16'(wr_en_regf_W), 16'h0001);

      // Same-cycle store and load returns the old contents.
      store(16'h0020, 16'h0011);
      idle();
      wr_en_dmem_M    = 1'b1;
      rd_en_M         = 1'b1;
      mux_rdata_sel_M = 1'b1;
      mem_addr_M      = 16'h0020;
      mem_wd_M        = 16'h0022;
      tick();
      check("rw_same old data", 16'(wb_data_W), 16'h0011);
      idle();
      rd_en_M         = 1'b1;
      mux_rdata_sel_M = 1'b1;
      mem_addr_M      = 16'h0020;
      tick();
      check("rw_same new data", 16'(wb_data_W), 16'h0022);

      // Write-back source priority.
      idle();
      alu_out_M     = 16'h1234;
      IN_PORT_M     = 8'h5C;
      mux_out_sel_M = 1'b1;
      tick();
      check("prio inport", 16'(wb_data_W), 16'h005C);
      mux_out_sel_M = 1'b0;
      tick();
      check("prio alu", 16'(wb_data_W), 16'h0034);
      mux_out_sel_M   = 1'b1;
      mux_rdata_sel_M = 1'b1;
      rd_en_M         = 1'b1;
      mem_addr_M      = 16'h0020;
      tick();
      check("prio mem", 16'(wb_data_W), 16'h0022);

      // Single RET.
      store(16'h00FF, 16'h003C);
      store(16'h00FE, 16'h004D);
      idle();
      is_ret_M   = 1'b1;
      mem_addr_M = 16'h00FF;
      tick();
      check("ret1 valid", 16'(ret_pc_valid), 16'h1);
      check("ret1 pc", 16'(ret_pc), 16'h003C);
      idle();
      tick();
      check("ret1 valid drop", 16'(ret_pc_valid), 16'h0);
      check("ret1 pc hold", 16'(ret_pc), 16'h003C);

      // Back-to-back RETs.
      is_ret_M   = 1'b1;
      mem_addr_M = 16'h00FF;
      tick();
      check("ret2a valid", 16'(ret_pc_valid), 16'h1);
      check("ret2a pc", 16'(ret_pc), 16'h003C);
      mem_addr_M = 16'h00FE;
      tick();
      check("ret2b valid", 16'(ret_pc_valid), 16'h1);
      check("ret2b pc", 16'(ret_pc), 16'h004D);
      idle();
      tick();
      check("ret2 valid drop", 16'(ret_pc_valid), 16'h0);
      check("ret2 pc hold", 16'(ret_pc), 16'h004D);
      check("ret addr_err", 16'(addr_err), 16'h0);

      // Out-of-range store is dropped and sets the sticky flag.
      store(16'h0005, 16'h005A);
      check("oor pre addr_err", 16'(addr_err), 16'h0);
      store(16'h0105, 16'h0077);
      check("oor store addr_err", 16'(addr_err), 16'h1);
      idle();
      rd_en_M         = 1'b1;
      mux_rdata_sel_M = 1'b1;
      mem_addr_M      = 16'h0005;
      tick();
      check("oor store dropped", 16'(wb_data_W), 16'h005A);
      check("oor addr_err sticky", 16'(addr_err), 16'h1);

      // Out-of-range load and RET read zero.
      mem_addr_M = 16'h0105;
      tick();
      check("oor load zero", 16'(wb_data_W), 16'h0000);
      idle();
      is_ret_M   = 1'b1;
      mem_addr_M = 16'h01FF;
      tick();
      check("oor ret valid", 16'(ret_pc_valid), 16'h1);
      check("oor ret pc", 16'(ret_pc), 16'h0000);

      // Output port update and hold.
      idle();
      out_port_sel_M = 1'b1;
      alu_out_M      = 16'h00C3;
      tick();
      check("out_port set", 16'(out_port), 16'h00C3);
      idle();
      alu_out_M = 16'hFFFF;
      tick();
      check("out_port hold", 16'(out_port), 16'h00C3);
      check("alu low byte wb", 16'(wb_data_W), 16'h00FF);
      check("addr_err still set", 16'(addr_err), 16'h1);

      // Only reset clears the sticky flag and the output port.
      reset = 1'b0;
      #1;
      check("final reset addr_err", 16'(addr_err), 16'h0);
      check("final reset out_port", 16'(out_port), 16'h0);
      reset = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
